// File: rtl/input_buffer_ctrl_pkg.sv
// Shared definitions for the input buffer fetch controller: FSM encoding and
// default parameter constants used by the controller and its parent.
package input_buffer_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_BIT_WIDTH     = 8;
    localparam int DEF_NUM_CHANNEL   = 3;
    localparam int DEF_NUM_RDATA     = 3;
    localparam int DEF_FF_DEPTH      = 16;
    localparam int DEF_FF_ADDR_WIDTH = 4;
    localparam int DEF_ADDR_WIDTH    = 32;
    localparam int DEF_CNT_WIDTH     = 16;
    localparam int DEF_MAX_OUTST     = 4;

endpackage

// File: rtl/input_buffer_ctrl.sv
// Fetches a frame of pixel words from memory into an external buffer and
// arbitrates consumer reads of NUM_RDATA words against buffer occupancy.
module input_buffer_ctrl
    import input_buffer_ctrl_pkg::*;
#(
    parameter int BIT_WIDTH     = DEF_BIT_WIDTH,
    parameter int NUM_CHANNEL   = DEF_NUM_CHANNEL,
    parameter int NUM_RDATA     = DEF_NUM_RDATA,
    parameter int FF_DEPTH      = DEF_FF_DEPTH,
    parameter int FF_ADDR_WIDTH = DEF_FF_ADDR_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int MAX_OUTST     = DEF_MAX_OUTST,
    parameter int DAT_WIDTH     = BIT_WIDTH * NUM_CHANNEL
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_start,
    input  logic [ADDR_WIDTH-1:0]    cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]     cfg_num_pix,
    input  logic [CNT_WIDTH-1:0]     cfg_num_rd,
    output logic                     mem_rd_req,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic                     mem_rd_gnt,
    input  logic [DAT_WIDTH-1:0]     mem_rd_data,
    input  logic                     mem_rd_vld,
    output logic [DAT_WIDTH-1:0]     buf_wr_data,
    output logic                     buf_wr_vld,
    output logic                     buf_data_req,
    input  logic [FF_ADDR_WIDTH:0]   buf_data_counter,
    input  logic                     pe_req,
    output logic                     pe_gnt,
    output logic                     busy,
    output logic                     done,
    output logic                     err_ovf
);

    // One guard bit over the configured count so comparisons never wrap.
    localparam int CW = CNT_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FF_DEPTH);
    localparam logic [CW-1:0] MAX_OUTST_C = CW'(MAX_OUTST);
    localparam logic [CW-1:0] NUM_RDATA_C = CW'(NUM_RDATA);

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_addr;
    logic [CW-1:0]         num_pix;
    logic [CW-1:0]         num_rd;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         served;
    logic [CW-1:0]         outst;
    logic [CW-1:0]         occ;
    logic                  issue;
    logic                  ret;
    logic                  launch;

    assign occ    = CW'(buf_data_counter);
    assign launch = (state == S_IDLE) && cfg_start;

    // Occupancy plus reads still in flight must fit, so a return never overruns.
    assign mem_rd_req  = (state == S_FETCH) && (issued < num_pix) &&
                         (outst < MAX_OUTST_C) && ((occ + outst) < DEPTH_C);
    assign mem_rd_addr = base_addr + ADDR_WIDTH'(issued);
    assign issue       = mem_rd_req && mem_rd_gnt;

    // Returns seen while idle belong to an aborted frame and are dropped.
    assign ret = mem_rd_vld && (state != S_IDLE);

    assign pe_gnt       = pe_req && (state != S_IDLE) &&
                          (occ >= NUM_RDATA_C) && (served < num_rd);
    assign buf_data_req = pe_gnt;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_start) begin
                    if ((cfg_num_pix == '0) || (cfg_num_rd == '0))
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                busy = 1'b1;
                if (issued >= num_pix)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if ((outst == '0) && !buf_wr_vld && (served >= num_rd))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            base_addr   <= '0;
            num_pix     <= '0;
            num_rd      <= '0;
            issued      <= '0;
            served      <= '0;
            outst       <= '0;
            buf_wr_vld  <= 1'b0;
            buf_wr_data <= '0;
            err_ovf     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                base_addr <= cfg_base_addr;
                num_pix   <= CW'(cfg_num_pix);
                num_rd    <= CW'(cfg_num_rd);
                issued    <= '0;
                served    <= '0;
                outst     <= '0;
            end else begin
                if (issue)
                    issued <= issued + CW'(1);
                if (pe_gnt)
                    served <= served + CW'(1);
                // Grant and return in the same cycle cancel out.
                case ({issue, ret && (outst != '0)})
                    2'b10:   outst <= outst + CW'(1);
                    2'b01:   outst <= outst - CW'(1);
                    default: outst <= outst;
                endcase
            end
            buf_wr_vld <= ret;
            if (ret)
                buf_wr_data <= mem_rd_data;
            if (buf_wr_vld && (occ == DEPTH_C))
                err_ovf <= 1'b1;
        end
    end

endmodule

// File: doc/input_buffer_ctrl.md
INPUT_BUFFER_CTRL -- requirements
Module: input_buffer_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BIT_WIDTH 8: bits per channel sample
- NUM_CHANNEL 3: channels per pixel word
- NUM_RDATA 3: pixel words returned per buffer read
- FF_DEPTH 16: buffer depth in words
- FF_ADDR_WIDTH 4: log2(FF_DEPTH)
- ADDR_WIDTH 32: memory address width
- CNT_WIDTH 16: pixel/read counter width
- MAX_OUTST 4: maximum in-flight memory reads
- DAT_WIDTH = BIT_WIDTH*NUM_CHANNEL
REQ-002 Ports (name, direction, width, meaning), one per line; one clock, reset synchronous active-low:
- clk in 1: single clock
- rst in 1: synchronous, active-low reset
- cfg_start in 1: one-cycle start pulse
- cfg_base_addr in ADDR_WIDTH: first pixel word address
- cfg_num_pix in CNT_WIDTH: pixel words to fetch
- cfg_num_rd in CNT_WIDTH: buffer reads to serve
- mem_rd_req out 1: memory read request
- mem_rd_addr out ADDR_WIDTH: memory read address
- mem_rd_gnt in 1: request accepted
- mem_rd_data in DAT_WIDTH: returned pixel word
- mem_rd_vld in 1: return valid, in order
- buf_wr_data out DAT_WIDTH: buffer write data
- buf_wr_vld out 1: buffer write strobe
- buf_data_req out 1: buffer read request
- buf_data_counter in FF_ADDR_WIDTH+1: buffer occupancy
- pe_req in 1: consumer wants NUM_RDATA words
- pe_gnt out 1: pe_req served this cycle
- busy out 1: frame in progress
- done out 1: one-cycle frame-complete pulse
- err_ovf out 1: sticky buffer overflow flag

Function
REQ-003 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on cfg_start; cfg_* latched on that edge.
REQ-004 cfg_start outside IDLE is ignored.
REQ-005 cfg_num_pix=0 or cfg_num_rd=0 with cfg_start: IDLE->DONE directly, no memory or buffer traffic.
REQ-006 FETCH: mem_rd_req=1 while issued<num_pix, outst<MAX_OUTST and buf_data_counter+outst<FF_DEPTH.
REQ-007 mem_rd_addr = base_addr + issued; issued and outst increment on req&gnt; req/addr hold until gnt.
REQ-008 mem_rd_vld: registered to buf_wr_data/buf_wr_vld next cycle (1-cycle latency); outst decrements.
REQ-009 Simultaneous grant and return leave outst unchanged.
REQ-010 FETCH->DRAIN when issued reaches num_pix.
REQ-011 buf_data_req=pe_gnt=pe_req & (buf_data_counter>=NUM_RDATA) & (served<num_rd), combinational, any non-IDLE state.
REQ-012 served increments on pe_gnt; reads remain servable during FETCH.
REQ-013 DRAIN->DONE when outst=0, no write pending and served=num_rd; DONE->IDLE unconditionally.
REQ-014 done=1 only in DONE (one cycle); busy=1 in FETCH and DRAIN.
REQ-015 err_ovf set when buf_wr_vld with buf_data_counter=FF_DEPTH; cleared only by reset.
REQ-016 Counter arithmetic at CNT_WIDTH+1 bits; address wraps modulo 2^ADDR_WIDTH.

Reset
REQ-017 rst=0 at clk edge: state IDLE; counters 0; all outputs 0; mid-frame reset drops in-flight returns.
REQ-018 mem_rd_vld arriving in IDLE is discarded: no buffer write, outst unchanged.

Structure
REQ-019 Shared package holds FSM state encoding and default parameter constants.
REQ-020 Single flat module, no sub-module; datapath buffer instantiated beside it by the parent.

Verification
REQ-021 base=0x100, num_pix=6, num_rd=2, gnt=1, return latency 2, pe_req=1 -> addrs 0x100..0x105, 6 writes, 2 grants, done 1 cycle.
REQ-022 buf_data_counter=14, outst=2 -> mem_rd_req=0 until occupancy drops.
REQ-023 gnt held low 5 cycles -> mem_rd_req and mem_rd_addr stable, issued unchanged.
REQ-024 num_pix=0 -> done 1 cycle after start; mem_rd_req never asserted.
REQ-025 rst=0 in FETCH with outst=3, then 3 returns -> no buf_wr_vld, state IDLE.
REQ-026 forced write at occupancy 16 -> err_ovf=1, stays 1 through next frame.
